// File: rtl/rf_wb_scheduler_pkg.sv
// Shared sizes and types for the register-file writeback scheduler.
// wb_req_t is the {rd, data} pair carried by the load-writeback queue.
package rf_wb_scheduler_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_AW     = $clog2(NREG);
  localparam int MEMQ_DEPTH = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Pipeline-facing bundle of the writeback scheduler: writeback sources, decode
// lookup, register-file write port and bypass results.
interface rf_wb_scheduler_if;
  import rf_wb_scheduler_pkg::*;

  logic      alu_wb_valid;
  reg_addr_t alu_wb_rd;
  xlen_t     alu_wb_data;
  logic      mem_wb_valid;
  logic      mem_wb_ready;
  reg_addr_t mem_wb_rd;
  xlen_t     mem_wb_data;
  logic      issue_load_valid;
  reg_addr_t issue_load_rd;
  logic      dec_valid;
  reg_addr_t dec_rs1;
  reg_addr_t dec_rs2;
  reg_addr_t dec_rd;
  logic      hazard_stall;
  logic      rf_write_enable;
  reg_addr_t rf_addr_rd;
  xlen_t     rf_data_rd;
  logic      byp_rs1_valid;
  xlen_t     byp_rs1_data;
  logic      byp_rs2_valid;
  xlen_t     byp_rs2_data;

  // Pipeline side drives requests and decode lookups.
  modport master (
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output mem_wb_valid, mem_wb_rd, mem_wb_data,
    output issue_load_valid, issue_load_rd,
    output dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  mem_wb_ready, hazard_stall,
    input  rf_write_enable, rf_addr_rd, rf_data_rd,
    input  byp_rs1_valid, byp_rs1_data, byp_rs2_valid, byp_rs2_data
  );

  // Scheduler side.
  modport slave (
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  issue_load_valid, issue_load_rd,
    input  dec_valid, dec_rs1, dec_rs2, dec_rd,
    output mem_wb_ready, hazard_stall,
    output rf_write_enable, rf_addr_rd, rf_data_rd,
    output byp_rs1_valid, byp_rs1_data, byp_rs2_valid, byp_rs2_data
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of writeback requests; head is visible combinationally
// so the arbiter can pop and write in the same cycle.
module rf_wb_fifo
  import rf_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = MEMQ_DEPTH
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Owns the register-file write port: ALU-first arbitration against a load queue,
// per-register load scoreboard for the decode stall, and registered write bypass.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  rf_wb_scheduler_if.slave  wb
);

  wb_req_t         q_head, q_push_req;
  logic            q_full, q_empty, q_push, q_pop;
  logic            alu_sel;
  logic            we_q, we_d;
  reg_addr_t       addr_q, addr_d;
  xlen_t           data_q, data_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            b1v_q, b1v_d, b2v_q, b2v_d;
  xlen_t           b1d_q, b1d_d, b2d_q, b2d_d;

  // Loads to x0 complete the handshake but never occupy a queue slot.
  assign wb.mem_wb_ready = ~q_full;
  assign q_push          = wb.mem_wb_valid & ~q_full & (wb.mem_wb_rd != '0);
  assign q_push_req      = '{rd: wb.mem_wb_rd, data: wb.mem_wb_data};

  assign alu_sel = wb.alu_wb_valid & (wb.alu_wb_rd != '0);
  assign q_pop   = ~alu_sel & ~q_empty;

  rf_wb_fifo #(.DEPTH(MEMQ_DEPTH)) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (q_push),
    .push_data_i (q_push_req),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (alu_sel) begin
      we_d   = 1'b1;
      addr_d = wb.alu_wb_rd;
      data_d = wb.alu_wb_data;
    end else if (q_pop) begin
      we_d   = 1'b1;
      addr_d = q_head.rd;
      data_d = q_head.data;
    end
  end

  // Clear applies before set so a same-cycle re-issue keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (q_pop) pending_d[q_head.rd] = 1'b0;
    if (wb.issue_load_valid) pending_d[wb.issue_load_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign wb.hazard_stall = wb.dec_valid &
                           (pending_q[wb.dec_rs1] | pending_q[wb.dec_rs2] | pending_q[wb.dec_rd]);

  // The RF returns pre-write data on a same-edge read, so forward the write in flight.
  always_comb begin
    b1v_d = we_q & (wb.dec_rs1 == addr_q) & (wb.dec_rs1 != '0);
    b2v_d = we_q & (wb.dec_rs2 == addr_q) & (wb.dec_rs2 != '0);
    b1d_d = b1v_d ? data_q : '0;
    b2d_d = b2v_d ? data_q : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      pending_q <= '0;
      b1v_q     <= 1'b0;
      b1d_q     <= '0;
      b2v_q     <= 1'b0;
      b2d_q     <= '0;
    end else begin
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      b1v_q     <= b1v_d;
      b1d_q     <= b1d_d;
      b2v_q     <= b2v_d;
      b2d_q     <= b2d_d;
    end
  end

  assign wb.rf_write_enable = we_q;
  assign wb.rf_addr_rd      = addr_q;
  assign wb.rf_data_rd      = data_q;
  assign wb.byp_rs1_valid   = b1v_q;
  assign wb.byp_rs1_data    = b1d_q;
  assign wb.byp_rs2_valid   = b2v_q;
  assign wb.byp_rs2_data    = b2d_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios plus random traffic, all checked
// each cycle against a queue/bit-array reference model of the writeback rules.
module tb_rf_wb_scheduler;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  rf_wb_scheduler_if bus ();

  rf_wb_scheduler dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wb      (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference model state: expected registered outputs for the current cycle.
  ent_t        m_q[$];
  bit [31:0]   m_pend;
  bit          e_we, e_b1v, e_b2v;
  logic [4:0]  e_addr;
  logic [31:0] e_data, e_b1d, e_b2d;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_pend = '0;
    e_we = 0; e_addr = '0; e_data = '0;
    e_b1v = 0; e_b1d = '0; e_b2v = 0; e_b2d = '0;
  endtask

  // One clock cycle: drive inputs, check all outputs against the model, advance the model.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                      input bit iv, input logic [4:0] ird,
                      input bit dv, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rdd);
    bit rdy, n_we, n_b1v, n_b2v;
    logic [4:0] n_addr;
    logic [31:0] n_data;
    ent_t e;
    @(negedge clock);
    bus.alu_wb_valid = av;  bus.alu_wb_rd = ard;  bus.alu_wb_data = ad;
    bus.mem_wb_valid = mv;  bus.mem_wb_rd = mrd;  bus.mem_wb_data = md;
    bus.issue_load_valid = iv; bus.issue_load_rd = ird;
    bus.dec_valid = dv; bus.dec_rs1 = r1; bus.dec_rs2 = r2; bus.dec_rd = rdd;
    #1;
    rdy = (m_q.size() < 2);
    chk("ready", bus.mem_wb_ready, rdy);
    chk("stall", bus.hazard_stall, dv && (m_pend[r1] || m_pend[r2] || m_pend[rdd]));
    chk("we", bus.rf_write_enable, e_we);
    if (e_we) begin
      chk("waddr", bus.rf_addr_rd, e_addr);
      chk("wdata", bus.rf_data_rd, e_data);
      $display("wb x%0d <= %08h t=%0t", e_addr, e_data, $time);
    end
    chk("b1v", bus.byp_rs1_valid, e_b1v);
    if (e_b1v) chk("b1d", bus.byp_rs1_data, e_b1d);
    chk("b2v", bus.byp_rs2_valid, e_b2v);
    if (e_b2v) chk("b2d", bus.byp_rs2_data, e_b2d);

    n_b1v = e_we && (r1 == e_addr) && (r1 != 0);
    n_b2v = e_we && (r2 == e_addr) && (r2 != 0);
    n_addr = e_addr; n_data = e_data;
    if (av && ard != 0) begin
      n_we = 1; n_addr = ard; n_data = ad;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      n_we = 1; n_addr = e.rd; n_data = e.data;
      m_pend[e.rd] = 1'b0;
    end else begin
      n_we = 0;
    end
    if (mv && rdy && mrd != 0) m_q.push_back(ent_t'{mrd, md});
    if (iv && ird != 0) m_pend[ird] = 1'b1;
    e_b1v = n_b1v; e_b1d = e_data;
    e_b2v = n_b2v; e_b2d = e_data;
    e_we = n_we; e_addr = n_addr; e_data = n_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.alu_wb_valid = 0; bus.mem_wb_valid = 0; bus.issue_load_valid = 0; bus.dec_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_we", bus.rf_write_enable, 0);
    chk("rst_addr", bus.rf_addr_rd, 0);
    chk("rst_data", bus.rf_data_rd, 0);
    chk("rst_ready", bus.mem_wb_ready, 1);
    chk("rst_b1v", bus.byp_rs1_valid, 0);
    chk("rst_b1d", bus.byp_rs1_data, 0);
    chk("rst_b2v", bus.byp_rs2_valid, 0);
    chk("rst_b2d", bus.byp_rs2_data, 0);
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int li;
    bit acc;
    logic [4:0] lrd [3];
    logic [4:0] r;
    bus.alu_wb_valid = 0; bus.alu_wb_rd = 0; bus.alu_wb_data = 0;
    bus.mem_wb_valid = 0; bus.mem_wb_rd = 0; bus.mem_wb_data = 0;
    bus.issue_load_valid = 0; bus.issue_load_rd = 0;
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0;
    model_clear();
    do_reset();
    idle(2);

    // Reset with two loads queued behind ALU traffic.
    step(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h12, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(3);

    // ALU priority over a queued load.
    step(1, 5, 32'hA, 1, 6, 32'hB, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 5, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Queue fills under continuous ALU writes; third load waits for a gap.
    lrd[0] = 7; lrd[1] = 8; lrd[2] = 9;
    li = 0;
    for (int c = 0; c < 8; c++) begin
      acc = (m_q.size() < 2) && (li < 3);
      step(c < 5, 1, 32'h100 + c, li < 3, (li < 3) ? lrd[li] : 5'd0, 32'h700 + li,
           0, 0, 0, 0, 0, 0);
      if (acc) li++;
    end
    idle(4);

    // Scoreboard: stall on x10 until its load is written, including a same-cycle re-issue.
    step(0, 0, 0, 0, 0, 0, 1, 10, 1, 10, 0, 0);
    step(1, 2, 32'h5, 1, 10, 32'hAAAA, 0, 0, 1, 10, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 10, 1, 10, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
    step(0, 0, 0, 1, 10, 32'hBBBB, 0, 0, 1, 0, 0, 10);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0);

    // Bypass of an in-flight write to rs2.
    step(1, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 3, 0);
    idle(2);

    // x0 never written, queued, pending or bypassed.
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);

    // Random traffic over a small register window to hit hazards and bypasses.
    for (int i = 0; i < 600; i++) begin
      r = 5'($urandom_range(0, 7));
      step($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 25) && !m_pend[r], r,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
      if (i == 300) do_reset();
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
